// File: rtl/dram_ctl_pkg.sv
// Shared definitions for the FPM SIMM controller: FSM states, address mux ranges, byte-lane decode.
// REF_* states exist only when DRAMCTL_REFRESH_EN is defined.
package dram_ctl_pkg;

   localparam int REFRESH_DIV    = 780;
   localparam int PRECHARGE_CLKS = 2;
   localparam int REF_RAS_CLKS   = 3;
   localparam int CNT_W          = 3;

   localparam int MA_W   = 11;
   localparam int ROW_HI = 23;
   localparam int ROW_LO = 13;
   localparam int COL_HI = 12;
   localparam int COL_LO = 2;

   typedef enum logic [3:0] {
      IDLE,
      ROW,
      COL,
      CAS,
      ACK,
      HOLD,
      PRE
`ifdef DRAMCTL_REFRESH_EN
      ,
      REF_CAS,
      REF_RAS
`endif
   } state_t;

   // Active-low lane mask for a 32-bit port; bit i is byte offset i (bit 0 = D31-24).
   // Reads enable every lane; writes cover offset..offset+len-1, clipped at lane 3.
   function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                            input logic [1:0] offset,
                                            input logic       rnw);
      int         first;
      int         last;
      logic [3:0] mask;
      first = int'(offset);
      last  = first + ((siz == 2'b00) ? 4 : int'(siz)) - 1;
      mask  = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (rnw || (i >= first && i <= last)) begin
            mask[i] = 1'b0;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a single sticky request.
// Only instantiated when DRAMCTL_REFRESH_EN is defined.
import dram_ctl_pkg::*;

module dram_refresh_timer #(
   parameter int DIV = REFRESH_DIV
) (
   input  logic DRAM_CLK,
   input  logic nRST,
   input  logic clear,
   output logic req
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] count_reg;
   logic          pending_reg;
   logic          wrap;

   assign wrap = (count_reg == CW'(DIV - 1));

   always_ff @(posedge DRAM_CLK or negedge nRST) begin
      if (!nRST) begin
         count_reg   <= '0;
         pending_reg <= 1'b0;
      end else begin
         count_reg <= wrap ? '0 : count_reg + CW'(1);
         // A clear on the wrap clock consumes that wrap; wraps while pending collapse into one.
         if (clear) begin
            pending_reg <= 1'b0;
         end else if (wrap) begin
            pending_reg <= 1'b1;
         end
      end
   end

   // The wrap itself counts as a request so the refresh can start on the wrap clock.
   assign req = pending_reg | wrap;

endmodule

// File: rtl/dram_ctl.sv
// FPM DRAM controller for one 72-pin SIMM: RAS/CAS sequencing, address mux, async DSACK termination.
// Define DRAMCTL_REFRESH_EN to compile in CAS-before-RAS refresh.
import dram_ctl_pkg::*;

module dram_ctl (
   input  logic        DRAM_CLK,
   input  logic        nRST,
   input  logic        nAS,
   input  logic        nRAMSEL,
   input  logic        RnW,
   input  logic [1:0]  SIZ,
   input  logic [23:0] ADDR,
   input  logic [7:0]  ADDR_HI,
   output logic [10:0] MA,
   output logic        nRAS,
   output logic [3:0]  nCAS,
   output logic        nWE,
   output logic [1:0]  nDSACK
);

   genvar gi;

   logic [1:0] sync_in;
   logic [1:0] synced;
   logic       nas_s;
   logic       nramsel_s;
   logic       hit;

   assign sync_in = {nRAMSEL, nAS};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         always_ff @(posedge DRAM_CLK or negedge nRST) begin
            if (!nRST) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= sync_in[gi];
               sync_reg <= meta_reg;
            end
         end
         assign synced[gi] = sync_reg;
      end
   endgenerate

   assign nas_s     = synced[0];
   assign nramsel_s = synced[1];
   assign hit       = !nas_s && !nramsel_s && (ADDR_HI == 8'h00);

   logic refresh_req;

`ifdef DRAMCTL_REFRESH_EN
   logic refresh_clear;

   dram_refresh_timer #(
      .DIV(REFRESH_DIV)
   ) u_refresh (
      .DRAM_CLK(DRAM_CLK),
      .nRST    (nRST),
      .clear   (refresh_clear),
      .req     (refresh_req)
   );
`else
   assign refresh_req = 1'b0;
`endif

   state_t             state_reg, state_next, go_state;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [MA_W-1:0]    ma_reg, ma_next;
   logic               nras_reg, nras_next;
   logic [3:0]         ncas_reg, ncas_next;
   logic               nwe_reg, nwe_next;
   logic               ndsack_reg, ndsack_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      go_state   = hit ? ROW : IDLE;
`ifdef DRAMCTL_REFRESH_EN
      if (refresh_req) begin
         go_state = REF_CAS;
      end
`endif

      case (state_reg)
         IDLE: state_next = go_state;
         ROW:  state_next = COL;
         COL:  state_next = CAS;
         CAS:  state_next = ACK;
         ACK:  state_next = HOLD;
         HOLD: begin
            if (nas_s) begin
               state_next = PRE;
               cnt_next   = CNT_W'(PRECHARGE_CLKS - 1);
            end
         end
         // Last precharge clock arbitrates like IDLE, so back-to-back RAS high time is exactly PRECHARGE_CLKS.
         PRE: begin
            if (cnt_reg == '0) begin
               state_next = go_state;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
`ifdef DRAMCTL_REFRESH_EN
         REF_CAS: begin
            state_next = REF_RAS;
            cnt_next   = CNT_W'(REF_RAS_CLKS - 1);
         end
         REF_RAS: begin
            if (cnt_reg == '0) begin
               state_next = PRE;
               cnt_next   = CNT_W'(PRECHARGE_CLKS - 1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

`ifdef DRAMCTL_REFRESH_EN
   assign refresh_clear = (state_next == REF_CAS);
`endif

   // Strobes are registered from the next state so every pin changes cleanly on the clock edge.
   always_comb begin
      ma_next     = ma_reg;
      nras_next   = 1'b1;
      ncas_next   = 4'hF;
      nwe_next    = 1'b1;
      ndsack_next = 1'b1;

      case (state_next)
         ROW: begin
            nras_next = 1'b0;
            ma_next   = ADDR[ROW_HI:ROW_LO];
         end
         COL: begin
            nras_next = 1'b0;
            ma_next   = ADDR[COL_HI:COL_LO];
            nwe_next  = RnW;
         end
         CAS: begin
            nras_next = 1'b0;
            nwe_next  = RnW;
            ncas_next = lane_mask(SIZ, ADDR[1:0], RnW);
         end
         ACK, HOLD: begin
            nras_next   = 1'b0;
            ncas_next   = ncas_reg;
            nwe_next    = nwe_reg;
            ndsack_next = 1'b0;
         end
`ifdef DRAMCTL_REFRESH_EN
         REF_CAS: begin
            ncas_next = 4'h0;
         end
         REF_RAS: begin
            nras_next = 1'b0;
            ncas_next = 4'h0;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge DRAM_CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         ma_reg     <= '0;
         nras_reg   <= 1'b1;
         ncas_reg   <= 4'hF;
         nwe_reg    <= 1'b1;
         ndsack_reg <= 1'b1;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ma_reg     <= ma_next;
         nras_reg   <= nras_next;
         ncas_reg   <= ncas_next;
         nwe_reg    <= nwe_next;
         ndsack_reg <= ndsack_next;
      end
   end

   assign MA     = ma_reg;
   assign nRAS   = nras_reg;
   assign nCAS   = ncas_reg;
   assign nWE    = nwe_reg;
   assign nDSACK = {2{ndsack_reg}};

endmodule

// File: tb/tb_dram_ctl.sv
// Self-checking bench for dram_ctl: vector table of CPU accesses plus hand-written corner sequences.
// Refresh sequences run only when DRAMCTL_REFRESH_EN is defined.
module tb_dram_ctl;

   logic        DRAM_CLK = 1'b0;
   logic        nRST     = 1'b0;
   logic        nAS      = 1'b1;
   logic        nRAMSEL  = 1'b1;
   logic        RnW      = 1'b1;
   logic [1:0]  SIZ      = 2'b00;
   logic [23:0] ADDR     = 24'h0;
   logic [7:0]  ADDR_HI  = 8'h0;
   logic [10:0] MA;
   logic        nRAS;
   logic [3:0]  nCAS;
   logic        nWE;
   logic [1:0]  nDSACK;

   dram_ctl dut (
      .DRAM_CLK(DRAM_CLK),
      .nRST    (nRST),
      .nAS     (nAS),
      .nRAMSEL (nRAMSEL),
      .RnW     (RnW),
      .SIZ     (SIZ),
      .ADDR    (ADDR),
      .ADDR_HI (ADDR_HI),
      .MA      (MA),
      .nRAS    (nRAS),
      .nCAS    (nCAS),
      .nWE     (nWE),
      .nDSACK  (nDSACK)
   );

   always #10 DRAM_CLK = ~DRAM_CLK;

   typedef struct {
      logic        rnw;
      logic [1:0]  siz;
      logic [23:0] addr;
      logic [10:0] exp_row;
      logic [10:0] exp_col;
      logic [3:0]  exp_cas;
      logic        exp_we;
   } vec_t;

   localparam int READ_LAT = 6;
   localparam int NVEC     = 7;

   vec_t vecs[NVEC];
   vec_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge DRAM_CLK);
      @(negedge DRAM_CLK);
   endtask

   // Leaves the bench on a negedge with nRST just released; the next posedge is clock 1.
   task automatic do_reset();
      @(negedge DRAM_CLK);
      nRST = 1'b0; nAS = 1'b1; nRAMSEL = 1'b1; RnW = 1'b1;
      SIZ = 2'b00; ADDR = 24'h0; ADDR_HI = 8'h0;
      @(negedge DRAM_CLK);
      @(negedge DRAM_CLK);
      nRST = 1'b1;
   endtask

   task automatic start_access(input logic rnw, input logic [1:0] siz, input logic [23:0] addr);
      RnW = rnw; SIZ = siz; ADDR = addr; ADDR_HI = 8'h00;
      nRAMSEL = 1'b0; nAS = 1'b0;
   endtask

   task automatic end_access(input string tag);
      int rel;
      rel = -1;
      nAS = 1'b1; nRAMSEL = 1'b1;
      for (int c = 1; c <= 10 && rel < 0; c++) begin
         tick();
         if (nDSACK == 2'b11) rel = c;
      end
      chk({tag, "_release_within_3"}, 32'(rel >= 1 && rel <= 3), 32'd1);
      chk({tag, "_strobes_released"}, 32'({nRAS, nCAS, nWE, nDSACK}), 32'hFF);
   endtask

   // Drives one access, pushes its expectation, and pops/compares when DSACK appears.
   task automatic run_vec(input int idx, input vec_t v);
      logic [10:0] row_seen, col_seen;
      logic [3:0]  cas_seen;
      logic        we_seen;
      bit          got_row, got_cas;
      int          lat;
      vec_t        e;
      string       tag;
      row_seen = '1; col_seen = '1; cas_seen = '1; we_seen = 1'b1;
      got_row = 0; got_cas = 0; lat = -1;
      tag = $sformatf("v%0d", idx);
      do_reset();
      start_access(v.rnw, v.siz, v.addr);
      exp_q.push_back(v);
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         tick();
         if (!got_row && nRAS == 1'b0) begin
            got_row = 1; row_seen = MA;
         end
         if (!got_cas && nCAS != 4'hF) begin
            got_cas = 1; col_seen = MA; cas_seen = nCAS; we_seen = nWE;
         end
         if (nDSACK == 2'b00) lat = c;
      end
      e = exp_q.pop_front();
      chk({tag, "_dsack_latency"}, 32'(lat), 32'(READ_LAT));
      chk({tag, "_row_addr"}, 32'(row_seen), 32'(e.exp_row));
      chk({tag, "_col_addr"}, 32'(col_seen), 32'(e.exp_col));
      chk({tag, "_ncas"}, 32'(cas_seen), 32'(e.exp_cas));
      chk({tag, "_nwe"}, 32'(we_seen), 32'(e.exp_we));
      end_access(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int active;
      int ras_low;
      int lat;

      // nCAS bit i is byte offset i: bit 0 = D31-24, bit 3 = D7-0.
      vecs[0] = '{1'b1, 2'b00, 24'h001004, 11'h000, 11'h401, 4'b0000, 1'b1}; // long read
      vecs[1] = '{1'b0, 2'b01, 24'h000003, 11'h000, 11'h000, 4'b0111, 1'b0}; // byte write, D7-0
      vecs[2] = '{1'b0, 2'b10, 24'h000001, 11'h000, 11'h000, 4'b1001, 1'b0}; // word write, middle lanes
      vecs[3] = '{1'b0, 2'b00, 24'h123456, 11'h091, 11'h515, 4'b0011, 1'b0}; // misaligned long write
      vecs[4] = '{1'b0, 2'b11, 24'hFFFFFD, 11'h7FF, 11'h7FF, 4'b0001, 1'b0}; // 3-byte write, top of SIMM
      vecs[5] = '{1'b1, 2'b01, 24'h000002, 11'h000, 11'h000, 4'b0000, 1'b1}; // byte read uses all lanes
      vecs[6] = '{1'b0, 2'b10, 24'h000003, 11'h000, 11'h000, 4'b0111, 1'b0}; // word write split at lane 3

      do_reset();
      chk("reset_values", 32'({MA, nRAS, nCAS, nWE, nDSACK}), 32'h000FF);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
      end

      // Address above 16MB: no strobes and no termination.
      do_reset();
      start_access(1'b0, 2'b00, 24'h001004);
      ADDR_HI = 8'h01;
      active = 0;
      for (int c = 1; c <= 70; c++) begin
         tick();
         if ({nRAS, nCAS, nWE, nDSACK} != 8'hFF) active++;
      end
      chk("miss_active_clocks", 32'(active), 32'd0);
      nAS = 1'b1; nRAMSEL = 1'b1; ADDR_HI = 8'h00;

      // nAS withdrawn while the row is open: cycle completes and nothing stays asserted.
      do_reset();
      start_access(1'b1, 2'b00, 24'h001004);
      ras_low = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (nRAS == 1'b0) ras_low++;
      end
      nAS = 1'b1; nRAMSEL = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (nRAS == 1'b0) ras_low++;
      end
      chk("abort_row_opened", 32'(ras_low > 0), 32'd1);
      chk("abort_all_released", 32'({nRAS, nCAS, nWE, nDSACK}), 32'hFF);

      // Reset asserted during ACK must drop every strobe without a clock edge.
      do_reset();
      start_access(1'b0, 2'b00, 24'h001004);
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         tick();
         if (nDSACK == 2'b00) lat = c;
      end
      chk("ack_reached_before_reset", 32'(lat), 32'(READ_LAT));
      nRST = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({MA, nRAS, nCAS, nWE, nDSACK}), 32'h000FF);
      @(posedge DRAM_CLK);
      #1;
      chk("held_reset_outputs", 32'({MA, nRAS, nCAS, nWE, nDSACK}), 32'h000FF);
      nAS = 1'b1; nRAMSEL = 1'b1;
      @(negedge DRAM_CLK);
      nRST = 1'b1;

`ifdef DRAMCTL_REFRESH_EN
      // Idle refresh: REF_CAS on clock 780, RAS follows on 781.
      do_reset();
      for (int c = 1; c <= 781; c++) begin
         tick();
         if (c == 779) chk("refresh_not_before_780", 32'({nRAS, nCAS}), 32'h1F);
         if (c == 780) chk("refresh_cas_at_780", 32'({nRAS, nCAS}), 32'h10);
         if (c == 781) chk("refresh_ras_at_781", 32'({nRAS, nCAS}), 32'h00);
      end

      // Hit and refresh on the same IDLE clock: refresh first, DSACK 6 clocks late.
      do_reset();
      for (int c = 1; c <= 777; c++) begin
         tick();
      end
      start_access(1'b1, 2'b00, 24'h001004);
      lat = -1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         tick();
         if (c == 3) chk("collision_ref_cas_first", 32'({nRAS, nCAS}), 32'h10);
         if (nDSACK == 2'b00) lat = c;
      end
      chk("collision_dsack_latency", 32'(lat), 32'(READ_LAT + 6));
      end_access("collision");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
